// File: rtl/id_pipe_buf.sv
// rtl/id_pipe_buf.sv - IF/ID first-word-fall-through instruction queue with flush and load-use bubble insertion
module id_pipe_buf #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_inst,
  output logic             out_bubble,
  input  logic             flush,
  input  logic             ex_load_valid,
  input  logic [4:0]       ex_load_rd,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      stall_cnt
);
  // DEPTH=1 keeps a one-bit pointer that never leaves zero
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic             push, pop, empty, hazard;
  logic             uses_rs1, uses_rs2;
  logic [PC_W-1:0]  head_pc;
  logic [31:0]      head_inst;
  logic [6:0]       opcode;
  logic [4:0]       rs1, rs2;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign head_pc   = pc_mem[rp];
  assign head_inst = inst_mem[rp];
  assign opcode    = head_inst[6:0];
  assign rs1       = head_inst[19:15];
  assign rs2       = head_inst[24:20];

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
      7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = ~empty & ex_load_valid & (ex_load_rd != 5'd0) &
                  ((uses_rs1 & (rs1 == ex_load_rd)) | (uses_rs2 & (rs2 == ex_load_rd)));

  assign out_valid  = ~empty & ~hazard;
  assign out_bubble = hazard;
  assign out_pc     = empty ? '0 : head_pc;
  assign out_inst   = empty ? '0 : head_inst;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      // stall_cnt survives flush so redirect-heavy code still shows its hazard cost
      if (hazard && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (push) wp <= ptr_next(wp);
        if (pop)  rp <= ptr_next(rp);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp]   <= in_pc;
      inst_mem[wp] <= in_inst;
    end
  end
endmodule

// File: tb/tb_id_pipe_buf.sv
// tb/tb_id_pipe_buf.sv - randomized self-checking bench for id_pipe_buf at DEPTH=2 and DEPTH=1
module tb_id_pipe_buf;
  logic        clk;
  logic        rst, in_valid, out_ready, flush, ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic [31:0] in_pc, in_inst;
  logic [1:0]  ir, ov, ob;
  logic [31:0] opc [2];
  logic [31:0] oin [2];
  logic [31:0] sc  [2];
  logic [1:0]  cnt_a;
  logic [0:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_pipe_buf #(.PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(ov[0]), .out_ready(out_ready), .out_pc(opc[0]), .out_inst(oin[0]), .out_bubble(ob[0]),
    .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .count(cnt_a), .stall_cnt(sc[0])
  );

  id_pipe_buf #(.PC_W(32), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(ov[1]), .out_ready(out_ready), .out_pc(opc[1]), .out_inst(oin[1]), .out_bubble(ob[1]),
    .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .count(cnt_b), .stall_cnt(sc[1])
  );

  // Model: per instance, a list whose element 0 is always the head
  logic [31:0] m_pc   [2][8];
  logic [31:0] m_inst [2][8];
  int          m_size [2];
  logic [31:0] m_stall[2];
  bit          started = 0;
  logic [31:0] issued[$];
  int          iss0 = 0, iss1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int depth(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit m_hazard(input int d);
    logic [31:0] i;
    logic [6:0]  op;
    bit          u1, u2;
    if (m_size[d] == 0 || !ex_load_valid || ex_load_rd == 5'd0) return 1'b0;
    i  = m_inst[d][0];
    op = i[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return (u1 && i[19:15] == ex_load_rd) || (u2 && i[24:20] == ex_load_rd);
  endfunction

  always @(posedge clk) begin
    bit hz, pop, push;
    for (int d = 0; d < 2; d++) begin
      hz = m_hazard(d);
      if (rst) begin
        m_size[d]  = 0;
        m_stall[d] = 0;
      end else begin
        if (hz && m_stall[d] != 32'hFFFF_FFFF) m_stall[d] = m_stall[d] + 1;
        if (flush) m_size[d] = 0;
        else begin
          pop  = (m_size[d] != 0) && !hz && out_ready;
          push = in_valid && (m_size[d] < depth(d));
          if (pop) begin
            for (int k = 0; k < 7; k++) begin
              m_pc[d][k]   = m_pc[d][k+1];
              m_inst[d][k] = m_inst[d][k+1];
            end
            m_size[d]--;
          end
          if (push) begin
            m_pc[d][m_size[d]]   = in_pc;
            m_inst[d][m_size[d]] = in_inst;
            m_size[d]++;
          end
        end
      end
    end
    if (rst) started = 1;
  end

  always @(negedge clk) begin
    bit          hz;
    logic [31:0] epc, einst, ecnt, acnt;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        hz    = m_hazard(d);
        epc   = (m_size[d] != 0) ? m_pc[d][0] : 32'h0;
        einst = (m_size[d] != 0) ? m_inst[d][0] : 32'h0;
        ecnt  = m_size[d];
        acnt  = (d == 0) ? {30'h0, cnt_a} : {31'h0, cnt_b};
        chk($sformatf("d%0d in_ready", d), ir[d], (m_size[d] < depth(d)) ? 1 : 0);
        chk($sformatf("d%0d out_valid", d), ov[d], (m_size[d] != 0 && !hz) ? 1 : 0);
        chk($sformatf("d%0d out_bubble", d), ob[d], hz ? 1 : 0);
        chk($sformatf("d%0d out_pc", d), opc[d], epc);
        chk($sformatf("d%0d out_inst", d), oin[d], einst);
        chk($sformatf("d%0d count", d), acnt, ecnt);
        chk($sformatf("d%0d stall_cnt", d), sc[d], m_stall[d]);
      end
      if (!rst && !flush && out_ready) begin
        if (ov[0]) begin issued.push_back(opc[0]); iss0++; end
        if (ov[1]) iss1++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; ex_load_valid = 0; ex_load_rd = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int          ops [9];
    logic [31:0] ri;
    ops = '{32'h37, 32'h17, 32'h6F, 32'h33, 32'h23, 32'h63, 32'h13, 32'h03, 32'h67};
    rst = 1; idle(); out_ready = 0; in_pc = 0; in_inst = 0;
    step(2);
    rst = 0;
    @(negedge clk);
    chk("reset out_valid", ov[0], 0);
    chk("reset in_ready", ir[0], 1);
    chk("reset count", {30'h0, cnt_a}, 0);
    chk("reset out_pc", opc[0], 0);

    // streaming with the decoder always ready
    issued.delete();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = i * 4; in_inst = 32'h13;
      step(1);
    end
    in_valid = 0;
    step(3);
    chk("stream issued", issued.size(), 3);
    if (issued.size() == 3) begin
      chk("stream order0", issued[0], 32'h0);
      chk("stream order1", issued[1], 32'h4);
      chk("stream order2", issued[2], 32'h8);
    end

    // backpressure: fill, hold third offer, then drain
    issued.delete();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = i * 4; in_inst = 32'h13;
      if (i < 2) step(1);
    end
    @(negedge clk);
    chk("full count", {30'h0, cnt_a}, 2);
    chk("full in_ready", ir[0], 0);
    out_ready = 1;
    step(2);
    in_valid = 0;
    step(3);
    chk("drain issued", issued.size(), 3);
    if (issued.size() == 3) begin
      chk("drain order0", issued[0], 32'h0);
      chk("drain order1", issued[1], 32'h4);
      chk("drain order2", issued[2], 32'h8);
    end

    // load-use hazard held for three cycles
    issued.delete();
    in_valid = 1; in_pc = 32'h100; in_inst = 32'h0002_8133;
    step(1);
    in_valid = 0; ex_load_valid = 1; ex_load_rd = 5;
    step(3);
    ex_load_valid = 0;
    @(negedge clk);
    chk("hazard stall_cnt d0", sc[0], 3);
    chk("hazard stall_cnt d1", sc[1], 3);
    step(2);
    chk("hazard issue once", issued.size(), 1);
    if (issued.size() == 1) chk("hazard issued pc", issued[0], 32'h100);

    // no bubble: LUI rd-only match, and rd=0
    out_ready = 0;
    in_valid = 1; in_pc = 32'h200; in_inst = 32'h0000_12B7;
    step(1);
    in_valid = 0; ex_load_valid = 1; ex_load_rd = 5;
    @(negedge clk);
    chk("lui no bubble", ob[0], 0);
    chk("lui valid", ov[0], 1);
    ex_load_rd = 0;
    out_ready = 1;
    step(1);
    out_ready = 0;
    in_valid = 1; in_pc = 32'h204; in_inst = 32'h0002_8133;
    step(1);
    in_valid = 0;
    @(negedge clk);
    chk("rd0 no bubble", ob[0], 0);
    ex_load_valid = 0; out_ready = 1;
    step(2);
    chk("stall_cnt held", sc[0], 3);

    // flush with two queued and a push offered
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_pc = 32'h300 + i * 4; in_inst = 32'h13;
      step(1);
    end
    in_pc = 32'h308; flush = 1;
    step(1);
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush count", {30'h0, cnt_a}, 0);
    chk("flush out_valid", ov[0], 0);
    chk("flush out_pc", opc[0], 0);
    chk("flush in_ready", ir[0], 1);
    out_ready = 1;
    step(3);

    // throughput: DEPTH=2 one per cycle, DEPTH=1 one per two cycles
    in_valid = 1; in_pc = 32'h400; in_inst = 32'h13;
    step(4);
    iss0 = 0; iss1 = 0;
    step(10);
    chk("throughput d0", iss0, 10);
    chk("throughput d1", iss1, 5);
    in_valid = 0;
    step(2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom % 500) == 0;
      in_valid      = ($urandom % 4) != 0;
      out_ready     = ($urandom % 3) != 0;
      flush         = ($urandom % 32) == 0;
      ex_load_valid = $urandom % 2;
      ex_load_rd    = 5'($urandom % 4);
      ri            = $urandom;
      ri[19:15]     = 5'($urandom % 4);
      ri[24:20]     = 5'($urandom % 4);
      ri[6:0]       = 7'(ops[$urandom % 9]);
      in_inst       = ri;
      in_pc         = $urandom;
      step(1);
    end

    // reset mid-stream overrides flush and traffic
    rst = 0; idle(); out_ready = 0;
    in_valid = 1; in_pc = 32'h500; in_inst = 32'h0002_8133;
    step(2);
    in_valid = 0; ex_load_valid = 1; ex_load_rd = 5;
    step(1);
    @(negedge clk);
    chk("pre-reset count", {30'h0, cnt_a}, 2);
    chk("pre-reset stall nonzero", (sc[0] != 0) ? 1 : 0, 1);
    rst = 1; in_valid = 1; flush = 1;
    step(1);
    rst = 0; idle();
    @(negedge clk);
    chk("mid reset out_valid", ov[0], 0);
    chk("mid reset out_bubble", ob[0], 0);
    chk("mid reset out_pc", opc[0], 0);
    chk("mid reset out_inst", oin[0], 0);
    chk("mid reset count", {30'h0, cnt_a}, 0);
    chk("mid reset stall_cnt", sc[0], 0);
    chk("mid reset in_ready", ir[0], 1);
    chk("mid reset stall_cnt d1", sc[1], 0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_pipe_buf.md
# id_pipe_buf

Parametrised IF→ID pipeline buffer: a DEPTH-entry first-word-fall-through queue of {pc, inst} pairs with valid/ready handshakes on both sides, a synchronous flush for branch/jump redirects, and load-use hazard bubble insertion. It sits between the fetch stage and the decoder. It replaces the free-running 64-bit IF/ID register, which had no stall, flush or backpressure. A saturating counter of hazard-stall cycles is exported for performance debug.

## Interface
- PC_W, 32, PC width in bits.
- DEPTH, 2, number of queue entries; legal values 1, 2, 4, 8.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue accepts; equals (count < DEPTH); no combinational path from out_ready.
- in_pc  in  PC_W  fetched pc.
- in_inst  in  32  fetched instruction.
- out_valid  out  1  head instruction presented to the decoder.
- out_ready  in  1  decoder consumes the head.
- out_pc  out  PC_W  head pc; 0 when empty.
- out_inst  out  32  head instruction; 0 when empty.
- out_bubble  out  1  head is present but held by a load-use hazard this cycle.
- flush  in  1  discard all queued and incoming instructions.
- ex_load_valid  in  1  EXE stage holds a load.
- ex_load_rd  in  5  destination register of that load.
- count  out  CNT_W  current occupancy.
- stall_cnt  out  32  saturating count of cycles with out_bubble=1.

## Operation
- Storage: DEPTH-entry circular buffer, write pointer wp, read pointer rp, each $clog2(DEPTH) bits (DEPTH=1: no pointers), plus count. Pointers wrap modulo DEPTH.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- count_next = count + push − pop. Simultaneous push and pop when full cannot occur, because in_ready=0 when full. Simultaneous push and pop when 0<count<DEPTH leaves count unchanged.
- Head decode, on the entry at rp: rs1 = inst[19:15], rs2 = inst[24:20], opcode = inst[6:0].
- uses_rs1 is 1 unless opcode ∈ {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- uses_rs2 is 1 only for opcode ∈ {0110011 R-type, 0100011 store, 1100011 branch}.
- hazard = (count≠0) & ex_load_valid & (ex_load_rd≠0) & ((uses_rs1 & rs1==ex_load_rd) | (uses_rs2 & rs2==ex_load_rd)).
- out_valid = (count≠0) & ~hazard; out_bubble = hazard. Both are combinational from the registered head and the ex_load_* inputs.
- out_pc and out_inst equal the head entry when count≠0; otherwise 0.
- Flush: wp, rp and count are set to 0 at the next edge. A push offered in the same cycle is dropped. A pop in the same cycle is not counted as consumed; the decoder must also ignore it.
- stall_cnt increments by 1 each cycle out_bubble=1, saturating at 32'hFFFF_FFFF. It is cleared only by rst, not by flush.
- Reset, including reset asserted mid-operation, overrides flush and all traffic. After the edge: count=0, wp=rp=0, stall_cnt=0.
- Entry payload registers need not be cleared on reset.

## Timing
- Reset values: out_valid=0, out_bubble=0, out_pc=0, out_inst=0, count=0, stall_cnt=0, in_ready=1.
- Latency: an instruction pushed at edge N is visible with out_valid=1 in cycle N+1, unless a hazard holds it.
- Throughput: 1 instruction/cycle when DEPTH≥2.
- DEPTH=1 sustains 1 per 2 cycles, because in_ready deasserts while the single entry is occupied.
- Hazard bubble: out_valid drops in the same cycle ex_load_* matches. It rises in the first cycle ex_load_valid drops or ex_load_rd changes. The head is neither lost nor duplicated.
- Flush takes effect at the next edge. In the cycle after the flush, out_valid=0 and in_ready=1.
- Full boundary: with count=DEPTH, in_valid is ignored. A pop in that cycle makes in_ready=1 in the next cycle.
- Empty boundary: with count=0 and out_ready=1, nothing is popped and count stays 0.

## Test plan
- Reset, then push pc 0x0, 0x4, 0x8 with out_ready=1, DEPTH=2 → outputs appear in order one cycle after each push; count never exceeds 1; no drops.
- Hold out_ready=0 and push 3 instructions → count reaches 2; in_ready=0 with 0x8 pending; after out_ready=1, order is 0x0, 0x4, 0x8.
- Head inst 0x0002_8133 (add x2,x5,x0), ex_load_valid=1, ex_load_rd=5 for 3 cycles → out_valid=0 and out_bubble=1 for exactly 3 cycles, stall_cnt=3, then the head issues once.
- Head LUI x5 (0x0000_12B7) with ex_load_rd=0, and head rd-only match ex_load_rd=5 on LUI → no bubble; ex_load_rd=0 on any head → no bubble.
- Queue 2 entries, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, out_pc=0; the flushed-cycle push does not appear.
- Assert rst mid-stream with count=2 and stall_cnt≠0 → next cycle all outputs at their reset values; DEPTH=1 run shows one issue every 2 cycles.
